// File: rtl/regfile_writeback.sv
// Register-file write-back buffer: a small in-order FIFO of {rd, data} results
// that drains into the register file one write per granted cycle. It also
// provides per-register pending flags and youngest-entry forwarding for two
// source operands.
module regfile_writeback #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            flush,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            rf_grant,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            fwd1_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd2_data,
  output logic [31:0]     pending
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Storage is deliberately not reset; every output that reads it is gated by
  // the occupancy count.
  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];

  logic push;
  logic pop;

  // A full buffer refuses pushes even when the head is draining this cycle.
  assign in_ready = (count_q < DepthC);
  assign rf_we    = (count_q != '0);

  // rd==0 results complete the handshake but are dropped.
  assign push = in_valid && in_ready && !flush && (in_rd != 5'd0);
  assign pop  = rf_we && rf_grant && !flush;

  // Head entry drives the register-file port; zeroed when empty.
  assign rf_waddr = rf_we ? mem_rd[rptr_q]   : 5'd0;
  assign rf_wdata = rf_we ? mem_data[rptr_q] : '0;

  // Next-state for pointers and count; flush overrides push and pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage write at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr_q]   <= in_rd;
      mem_data[wptr_q] <= in_data;
    end
  end

  // Pending flags and forwarding: walk entries oldest to youngest so the last
  // match seen is the youngest one.
  always_comb begin
    pending   = '0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CntW'(k) < count_q) begin
        pending[mem_rd[rptr_q + PtrW'(k)]] = 1'b1;
        if ((rs1_addr != 5'd0) && (mem_rd[rptr_q + PtrW'(k)] == rs1_addr)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_data[rptr_q + PtrW'(k)];
        end
        if ((rs2_addr != 5'd0) && (mem_rd[rptr_q + PtrW'(k)] == rs2_addr)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_data[rptr_q + PtrW'(k)];
        end
      end
    end
    pending[0] = 1'b0;
  end

endmodule
